// File: rtl/pattern_detector.sv
// ---------------------------------------------------------------------------
// pattern_detector
//
// Mealy serial-bit pattern detector. Matches a runtime-loadable
// PATTERN_LEN-bit pattern (MSB received first) on a qualified serial stream.
// Overlapping or non-overlapping detection is selectable. A saturating
// counter records the number of matches.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset, overrides all other inputs
//   data_in_i      serial data bit
//   in_valid_i     data_in_i is accepted this cycle when high
//   cfg_load_i     load cfg_pattern_i / cfg_overlap_i and clear match history
//   cfg_pattern_i  new pattern, MSB first-received
//   cfg_overlap_i  1 = overlapping matches allowed, 0 = non-overlapping
//   count_clear_i  clear match_count_o (wins over a same-cycle match)
//   detected_o     same-cycle strobe: the accepted bit completes a match
//   armed_o        history is full, so the next matching bit will fire
//   match_count_o  saturating count of matches since reset or clear
// ---------------------------------------------------------------------------
module pattern_detector #(
    parameter int                     PATTERN_LEN     = 3,
    parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 3'b101,
    parameter int                     COUNT_W         = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   data_in_i,
    input  logic                   in_valid_i,
    input  logic                   cfg_load_i,
    input  logic [PATTERN_LEN-1:0] cfg_pattern_i,
    input  logic                   cfg_overlap_i,
    input  logic                   count_clear_i,
    output logic                   detected_o,
    output logic                   armed_o,
    output logic [COUNT_W-1:0]     match_count_o
);

    localparam int                FW       = $clog2(PATTERN_LEN);
    localparam logic [FW-1:0]     FILL_MAX = FW'(PATTERN_LEN - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
    logic                   overlap_q, overlap_d;
    logic [PATTERN_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [COUNT_W-1:0]     match_count_q, match_count_d;

    // History plus the incoming bit; its upper bit is the oldest bit.
    logic [PATTERN_LEN-1:0] window;
    logic                   match;

    assign window = {hist_q, data_in_i};

    // A load cycle discards the incoming bit, so it can never complete a match.
    assign match = in_valid_i && !cfg_load_i && (fill_q == FILL_MAX)
                   && (window == pattern_q);

    always_comb begin
        pattern_d     = pattern_q;
        overlap_d     = overlap_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        match_count_d = match_count_q;

        if (cfg_load_i) begin
            pattern_d = cfg_pattern_i;
            overlap_d = cfg_overlap_i;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid_i) begin
            hist_d = window[PATTERN_LEN-2:0];
            if (match && !overlap_q) begin
                // Non-overlapping: matched bits must not seed the next match.
                hist_d = '0;
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end

        if (count_clear_i) begin
            match_count_d = '0;
        end else if (match && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pattern_q     <= DEFAULT_PATTERN;
            overlap_q     <= 1'b1;
            hist_q        <= '0;
            fill_q        <= '0;
            match_count_q <= '0;
        end else begin
            pattern_q     <= pattern_d;
            overlap_q     <= overlap_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            match_count_q <= match_count_d;
        end
    end

    // The strobe is held low during reset even if a match would otherwise show.
    assign detected_o    = match && !reset_i;
    assign armed_o       = (fill_q == FILL_MAX);
    assign match_count_o = match_count_q;

endmodule

// File: tb/tb_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector
//
// Bench for pattern_detector. Three instances share one stimulus bus:
//   u_d3  : PATTERN_LEN 3, default 101, 8-bit counter (table-driven)
//   u_d8  : PATTERN_LEN 8, default A5 (gapped stream)
//   u_dcw : PATTERN_LEN 3, default 111, 2-bit counter (saturation/clear)
// Inputs change 1 time unit after a rising edge; detected_o is sampled on
// the falling edge, registered outputs 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, data_in, in_valid, cfg_load, cfg_overlap, count_clear;
    logic [2:0] cfg_pattern3;
    logic [7:0] cfg_pattern8;

    logic       det3, arm3, det8, arm8, detc, armc;
    logic [7:0] cnt3, cnt8;
    logic [1:0] cntc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_detector #(.PATTERN_LEN(3), .DEFAULT_PATTERN(3'b101), .COUNT_W(8)) u_d3 (
        .clk_i(clk), .reset_i(reset), .data_in_i(data_in), .in_valid_i(in_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern3), .cfg_overlap_i(cfg_overlap),
        .count_clear_i(count_clear), .detected_o(det3), .armed_o(arm3), .match_count_o(cnt3));

    pattern_detector #(.PATTERN_LEN(8), .DEFAULT_PATTERN(8'hA5), .COUNT_W(8)) u_d8 (
        .clk_i(clk), .reset_i(reset), .data_in_i(data_in), .in_valid_i(in_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern8), .cfg_overlap_i(cfg_overlap),
        .count_clear_i(count_clear), .detected_o(det8), .armed_o(arm8), .match_count_o(cnt8));

    pattern_detector #(.PATTERN_LEN(3), .DEFAULT_PATTERN(3'b111), .COUNT_W(2)) u_dcw (
        .clk_i(clk), .reset_i(reset), .data_in_i(data_in), .in_valid_i(in_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern3), .cfg_overlap_i(cfg_overlap),
        .count_clear_i(count_clear), .detected_o(detc), .armed_o(armc), .match_count_o(cntc));

    typedef struct {
        logic       rst;
        logic       ld;
        logic [2:0] pat;
        logic       ov;
        logic       v;
        logic       d;
        logic       clr;
        logic       exp_det;   // detected in this cycle
        int         exp_fill;  // fill after the edge
        int         exp_cnt;   // match_count after the edge
    } vec_t;

    vec_t vecs[31];

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [2:0] pat,
                         input logic ov, input logic v, input logic d, input logic clr);
        reset       = rst;
        cfg_load    = ld;
        cfg_pattern3 = pat;
        cfg_pattern8 = 8'h00;
        cfg_overlap = ov;
        in_valid    = v;
        data_in     = d;
        count_clear = clr;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic ld, input logic [2:0] pat,
                                input logic ov, input logic v, input logic d, input logic clr,
                                input logic ed, input int ef, input int ec);
        vec_t r;
        r.rst = rst; r.ld = ld; r.pat = pat; r.ov = ov; r.v = v; r.d = d; r.clr = clr;
        r.exp_det = ed; r.exp_fill = ef; r.exp_cnt = ec;
        return r;
    endfunction

    initial begin
        logic [7:0] a5;
        logic       dsamp;
        int         exp_c;

        //               rst ld pat     ov v  d  clr  det fill cnt
        vecs[0]  = mk(1, 0, 3'b000, 0, 0, 0, 0,   0, 0, 0);
        // default 101 overlapping, stream 1,0,1,0,1
        vecs[1]  = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 1, 0);
        vecs[2]  = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 0);
        vecs[3]  = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 1);
        vecs[4]  = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 1);
        vecs[5]  = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 2);
        // load 101 non-overlapping (and clear the count), same stream
        vecs[6]  = mk(0, 1, 3'b101, 0, 0, 0, 1,   0, 0, 0);
        vecs[7]  = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 1, 0);
        vecs[8]  = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 0);
        vecs[9]  = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 0, 1);
        vecs[10] = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 1, 1);
        vecs[11] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 2, 1);
        // load 111 overlapping, stream 1,1,1,1
        vecs[12] = mk(0, 1, 3'b111, 1, 0, 0, 0,   0, 0, 1);
        vecs[13] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 1, 1);
        vecs[14] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 2, 1);
        vecs[15] = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 2);
        vecs[16] = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 3);
        // gap with a matching bit on data_in must not fire; then clear
        vecs[17] = mk(0, 0, 3'b000, 0, 0, 1, 0,   0, 2, 3);
        vecs[18] = mk(0, 0, 3'b000, 0, 0, 0, 1,   0, 2, 0);
        // reset mid-stream after 1,0 of 101
        vecs[19] = mk(0, 1, 3'b101, 1, 0, 0, 0,   0, 0, 0);
        vecs[20] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 1, 0);
        vecs[21] = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 0);
        vecs[22] = mk(1, 0, 3'b000, 0, 1, 1, 0,   0, 0, 0);
        vecs[23] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 1, 0);
        vecs[24] = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 0);
        vecs[25] = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 1);
        // history now 01; a 0 leaves it one bit short of 101
        vecs[26] = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 2, 1);
        // load 011 on the completing bit: suppressed, new pattern from next bit
        vecs[27] = mk(0, 1, 3'b011, 1, 1, 1, 0,   0, 0, 1);
        vecs[28] = mk(0, 0, 3'b000, 0, 1, 0, 0,   0, 1, 1);
        vecs[29] = mk(0, 0, 3'b000, 0, 1, 1, 0,   0, 2, 1);
        vecs[30] = mk(0, 0, 3'b000, 0, 1, 1, 0,   1, 2, 2);

        drive(1, 0, 3'b000, 0, 0, 0, 0);
        to_edge();

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].pat, vecs[i].ov,
                  vecs[i].v, vecs[i].d, vecs[i].clr);
            @(negedge clk);
            check("d3_detected", i, int'(det3), int'(vecs[i].exp_det));
            to_edge();
            check("d3_fill",  i, int'(u_d3.fill_q), vecs[i].exp_fill);
            check("d3_armed", i, int'(arm3), (vecs[i].exp_fill == 2) ? 1 : 0);
            check("d3_count", i, int'(cnt3), vecs[i].exp_cnt);
        end

        // PATTERN_LEN 8: A5 MSB-first with in_valid toggling 1,0
        drive(1, 0, 3'b000, 0, 0, 0, 0);
        to_edge();
        check("d8_reset_count", 0, int'(cnt8), 0);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 3'b000, 0, 1, a5[7-i], 0);
            @(negedge clk);
            check("d8_detected_valid", i, int'(det8), (i == 7) ? 1 : 0);
            to_edge();
            // complement of the next bit on the idle cycle
            dsamp = (i < 7) ? ~a5[6-i] : 1'b1;
            drive(0, 0, 3'b000, 0, 0, dsamp, 0);
            @(negedge clk);
            check("d8_detected_gap", i, int'(det8), 0);
            to_edge();
        end
        check("d8_count", 0, int'(cnt8), 1);
        check("d8_armed", 0, int'(arm8), 1);

        // COUNT_W 2, pattern 111 overlapping: saturation then clear+match
        drive(1, 0, 3'b000, 0, 0, 0, 0);
        to_edge();
        exp_c = 0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 3'b000, 0, 1, 1, 0);
            @(negedge clk);
            check("cw_detected", i, int'(detc), (i >= 2) ? 1 : 0);
            to_edge();
            if (i >= 2 && exp_c < 3) exp_c++;
            check("cw_count", i, int'(cntc), exp_c);
        end
        check("cw_armed", 0, int'(armc), 1);
        drive(0, 0, 3'b000, 0, 1, 1, 1);
        @(negedge clk);
        check("cw_clear_detected", 0, int'(detc), 1);
        to_edge();
        check("cw_clear_count", 0, int'(cntc), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach its end, expected finish before 20000");
        $fatal(1);
    end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised Mealy serial-bit pattern detector, the successor to the fixed three-bit '101' detector. It matches a runtime-loadable PATTERN_LEN-bit pattern on a qualified serial stream, with selectable overlapping or non-overlapping detection and a saturating match counter. It sits on the serial input path of the design and feeds framing and alarm logic with a same-cycle detect strobe.

## Interface
- PATTERN_LEN, 3: pattern length in bits, legal range 2..16.
- DEFAULT_PATTERN, 3'b101: pattern value after reset, PATTERN_LEN bits wide; MSB is the first bit received.
- COUNT_W, 8: width of the match counter.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk, overrides all other inputs.
- data_in  input  1  serial data bit.
- in_valid  input  1  data_in is accepted this cycle when high.
- cfg_load  input  1  loads cfg_pattern and cfg_overlap; clears match history.
- cfg_pattern  input  PATTERN_LEN  new pattern, MSB first-received.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- count_clear  input  1  clears match_count.
- detected  output  1  Mealy strobe: the accepted bit this cycle completes a match.
- armed  output  1  fill == PATTERN_LEN-1 (next matching bit will fire).
- match_count  output  COUNT_W  number of matches since reset or clear, saturating.

## Operation
- Registers:
  - pattern_q (PATTERN_LEN bits).
  - overlap_q (1 bit).
  - hist (PATTERN_LEN-1 bits): most recent accepted bits; LSB is the newest.
  - fill (0..PATTERN_LEN-1): count of valid bits in hist.
  - match_count.
- State is fill. It increments per accepted bit and saturates at PATTERN_LEN-1.
- Match condition: in_valid && !cfg_load && fill == PATTERN_LEN-1 && {hist, data_in} == pattern_q.
- detected equals the match condition, combinationally from current registers and inputs. It is 0 whenever in_valid is 0.
- On an accepted bit: hist shifts left with data_in entering the LSB.
- On a match with overlap_q = 0: fill returns to 0 and hist is cleared, so the matched bits are not reused.
- On a match with overlap_q = 1: fill stays at PATTERN_LEN-1, so suffix/prefix overlaps are detected.
- in_valid = 0: no state change.
- cfg_load = 1:
  - pattern_q <= cfg_pattern; overlap_q <= cfg_overlap; fill <= 0; hist <= 0.
  - data_in is discarded that cycle even if in_valid = 1; detected = 0.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each detected.
  - Holds at all-ones (2^COUNT_W - 1) and does not wrap.
  - count_clear forces 0. If count_clear and detected occur in the same cycle, clear wins and the result is 0.
- Reset values: pattern_q = DEFAULT_PATTERN, overlap_q = 1, fill = 0, hist = 0, match_count = 0.
- Resulting output values in reset: detected = 0 (forced), armed = 0, match_count = 0.
- Reset mid-stream discards any partial match. The first post-reset match needs PATTERN_LEN fresh accepted bits.

## Timing
- detected latency: 0 cycles, asserted in the same cycle as the final accepted bit of the pattern.
- armed and match_count are registered. They reflect a cycle's events in the following cycle.
- A new pattern applies to the first bit accepted in the cycle after cfg_load.
- Minimum spacing between matches:
  - overlap: 1 cycle, for self-overlapping patterns such as all-ones.
  - non-overlap: PATTERN_LEN accepted bits.
- Gaps (in_valid = 0) between bits are transparent to matching.
- No combinational path from inputs to any output except detected.

## Test plan
- Default config, stream 1,0,1,0,1 with in_valid held high: detected on bits 3 and 5; match_count = 2.
- cfg_load with cfg_pattern = 101, cfg_overlap = 0, same stream: detected on bit 3 only; match_count = 1. Reload with cfg_overlap = 1, then send stream 1,1,1,1 with pattern 111: detected on bits 3 and 4.
- PATTERN_LEN = 8, pattern 8'hA5, stream 0xA5 MSB-first with in_valid toggling 1,0 per cycle: detected only on the eighth accepted bit; detected stays 0 in every in_valid = 0 cycle.
- COUNT_W = 2, five matches on an all-ones pattern with overlap: match_count sequence 1,2,3,3,3. Then assert count_clear and a match in the same cycle: match_count = 0.
- After bits 1,0 have been accepted with pattern 101, assert reset for one cycle, then send 1: detected = 0, and fill, armed and match_count read 0. The full 1,0,1 then fires.
- cfg_load with in_valid = 1 on the completing bit of a pending match: detected = 0 and fill = 0; the new pattern is matched from the next accepted bit.
